// File: rtl/fire_pkg.sv
// Shared types and helpers for the fire4 squeeze engine: FSM state encoding,
// accumulator sizing and the signed saturation used on every lane output.
package fire_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } fire_state_e;

    // Guard bits above the full-precision product so CH-long sums cannot wrap.
    localparam int ACC_GUARD = 8;

    function automatic int acc_width(input int w);
        return 2 * w + ACC_GUARD;
    endfunction

    // Clamp a sign-extended value to the range of a w-bit signed word.
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] x,
                                                      input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/fire_mac_lane.sv
// One output-channel lane: signed multiply-accumulate with clear, followed by
// arithmetic shift, saturation and optional ReLU (FIRE4_SQUEEZE_RELU_EN).
module fire_mac_lane
    import fire_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [WIDTH-1:0] act,
    input  logic signed [WIDTH-1:0] w,
    output logic signed [WIDTH-1:0] res
);
    localparam int ACC_W  = acc_width(WIDTH);
    localparam int PROD_W = 2 * WIDTH;

    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_d;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  shifted;
    logic signed [63:0]       wide;
    logic signed [63:0]       clamped;
    logic signed [WIDTH-1:0]  sat_val;

    always_comb begin
        prod     = act * w;
        prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
        acc_d    = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + prod_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    always_comb begin
        shifted = acc_q >>> FRAC;
        wide    = {{(64 - ACC_W){shifted[ACC_W-1]}}, shifted};
        clamped = sat_signed(wide, WIDTH);
        sat_val = WIDTH'(clamped);
`ifdef FIRE4_SQUEEZE_RELU_EN
        res = sat_val[WIDTH-1] ? '0 : sat_val;
`else
        res = sat_val;
`endif
    end

endmodule

// File: rtl/fire4_squeeze_engine.sv
// Fire4 squeeze 1x1 convolution: streams CH activations per pixel against NUM
// parallel MAC lanes fed by a weight ROM. Optional fused ReLU: FIRE4_SQUEEZE_RELU_EN.
module fire4_squeeze_engine
    import fire_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int ADDR  = 10,
    parameter int NUM   = 32,
    parameter int CH    = 128,
    parameter int NPIX  = 729,
    parameter int FRAC  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic signed [WIDTH-1:0]     act_in,
    input  logic                        act_valid,
    output logic                        act_ready,
    output logic [ADDR-1:0]             rom_addr,
    input  logic [NUM-1:0][WIDTH-1:0]   w_in,
    output logic [NUM-1:0][WIDTH-1:0]   res_out,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        busy,
    output logic                        done
);
    localparam int CW = (CH > 1) ? $clog2(CH) : 1;
    localparam int PW = (NPIX > 1) ? $clog2(NPIX) : 1;

    fire_state_e             state_q, state_d;
    logic [CW-1:0]           ch_cnt_q, ch_cnt_d;
    logic [PW-1:0]           pix_cnt_q, pix_cnt_d;
    logic signed [WIDTH-1:0] act_d_q, act_d_d;
    logic                    v_d_q, v_d_d;
    logic                    done_q, done_d;
    logic                    acc_clr;
    logic [NUM-1:0][WIDTH-1:0] lane_res;

    always_comb begin
        state_d   = state_q;
        ch_cnt_d  = ch_cnt_q;
        pix_cnt_d = pix_cnt_q;
        act_d_d   = act_d_q;
        v_d_d     = 1'b0;
        done_d    = 1'b0;
        acc_clr   = 1'b0;
        act_ready = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    ch_cnt_d  = '0;
                    pix_cnt_d = '0;
                    acc_clr   = 1'b1;
                end
            end
            ST_RUN: begin
                act_ready = 1'b1;
                if (act_valid) begin
                    act_d_d = act_in;
                    v_d_d   = 1'b1;
                    if (ch_cnt_q == CW'(CH - 1)) begin
                        ch_cnt_d = '0;
                        state_d  = ST_DRAIN;
                    end else begin
                        ch_cnt_d = ch_cnt_q + 1'b1;
                    end
                end
            end
            // Last product lands in the accumulators on this state's exit edge.
            ST_DRAIN: begin
                state_d = ST_OUT;
            end
            ST_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    acc_clr = 1'b1;
                    if (pix_cnt_q == PW'(NPIX - 1)) begin
                        pix_cnt_d = '0;
                        state_d   = ST_IDLE;
                        done_d    = 1'b1;
                    end else begin
                        pix_cnt_d = pix_cnt_q + 1'b1;
                        state_d   = ST_RUN;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ch_cnt_q  <= '0;
            pix_cnt_q <= '0;
            act_d_q   <= '0;
            v_d_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ch_cnt_q  <= ch_cnt_d;
            pix_cnt_q <= pix_cnt_d;
            act_d_q   <= act_d_d;
            v_d_q     <= v_d_d;
            done_q    <= done_d;
        end
    end

    // The ROM answers one cycle after the address, matching the act_d register.
    assign rom_addr = ADDR'(ch_cnt_q);
    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;

    for (genvar i = 0; i < NUM; i++) begin : g_lane
        fire_mac_lane #(
            .WIDTH (WIDTH),
            .FRAC  (FRAC)
        ) u_lane (
            .clk (clk),
            .rst (rst),
            .clr (acc_clr),
            .en  (v_d_q),
            .act (act_d_q),
            .w   (w_in[i]),
            .res (lane_res[i])
        );
    end

    assign res_out = (state_q == ST_OUT) ? lane_res : '0;

endmodule

// File: tb/tb_fire4_squeeze_engine.sv
// Scoreboard bench for fire4_squeeze_engine: directed pixels with hand-computed
// results, backpressure, frame end, mid-pixel reset and start-while-busy.
module tb_fire4_squeeze_engine;
    localparam int WIDTH = 16;
    localparam int ADDR  = 10;
    localparam int NUM   = 4;
    localparam int CH    = 128;
    localparam int NPIX  = 3;
    localparam int FRAC  = 8;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        start;
    logic signed [WIDTH-1:0]     act_in;
    logic                        act_valid;
    logic                        act_ready;
    logic [ADDR-1:0]             rom_addr;
    logic [NUM-1:0][WIDTH-1:0]   w_in;
    logic [NUM-1:0][WIDTH-1:0]   res_out;
    logic                        out_valid;
    logic                        out_ready;
    logic                        busy;
    logic                        done;

    logic [WIDTH-1:0] rom [CH][NUM];
    int  exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc = 0;
    int  last_acc_cyc = 0;
    int  frame_hs = 0;
    int  done_cnt = 0;
    bit  bp_arm = 1'b0;

    fire4_squeeze_engine #(
        .WIDTH (WIDTH), .ADDR (ADDR), .NUM (NUM), .CH (CH), .NPIX (NPIX), .FRAC (FRAC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .act_in    (act_in),
        .act_valid (act_valid),
        .act_ready (act_ready),
        .rom_addr  (rom_addr),
        .w_in      (w_in),
        .res_out   (res_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Weight ROM with one cycle of read latency.
    always @(posedge clk) begin
        for (int i = 0; i < NUM; i++) w_in[i] <= rom[int'(rom_addr)][i];
    end

    task automatic chk(input string nm, input longint a, input longint e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, a, e, cyc);
        end
    endtask

    function automatic logic signed [WIDTH-1:0] act_of(input int p, input int ch);
        case (p)
            0: return 16'sd256;
            1: return -16'sd128;
            2: return 16'sd16;
            3: return -16'sd256;
            default: return (ch < 64) ? 16'sd256 : -16'sd256;
        endcase
    endfunction

    function automatic logic signed [WIDTH-1:0] w_of(input int p, input int ch, input int ln);
        case (p)
            0, 1: return 16'sd256;
            2: case (ln) 0: return 16'sd256; 1: return -16'sd256; 2: return 16'sd128; default: return 16'sd0; endcase
            3: case (ln) 0: return 16'sd256; 1: return -16'sd256; 2: return 16'sd512; default: return 16'sd1; endcase
            default: case (ln)
                0: return (ch < 64) ? 16'sd256 : 16'sd0;
                1: return (ch < 64) ? 16'sd0 : 16'sd256;
                2: return 16'sd256;
                default: return (ch == CH - 1) ? 16'sd256 : 16'sd0;
            endcase
        endcase
    endfunction

    // Hand-computed lane results for each pattern.
    function automatic longint exp_lane(input int p, input int ln);
`ifdef FIRE4_SQUEEZE_RELU_EN
        case (p)
            0: return 32767;
            1: return 0;
            2: case (ln) 0: return 2048; 1: return 0; 2: return 1024; default: return 0; endcase
            3: case (ln) 1: return 32767; default: return 0; endcase
            default: case (ln) 0: return 16384; default: return 0; endcase
        endcase
`else
        case (p)
            0: return 32767;
            1: return -16384;
            2: case (ln) 0: return 2048; 1: return -2048; 2: return 1024; default: return 0; endcase
            3: case (ln) 0: return -32768; 1: return 32767; 2: return -32768; default: return -128; endcase
            default: case (ln) 0: return 16384; 1: return -16384; 2: return 0; default: return -256; endcase
        endcase
`endif
    endfunction

    function automatic longint lane_val(input logic [NUM-1:0][WIDTH-1:0] v, input int ln);
        logic signed [WIDTH-1:0] t;
        t = v[ln];
        return longint'(t);
    endfunction

    task automatic fill_rom(input int p);
        for (int c = 0; c < CH; c++)
            for (int l = 0; l < NUM; l++) rom[c][l] = w_of(p, c, l);
    endtask

    task automatic send_pixel(input int p, input bit toggle, input int start_at, input int nch);
        bit acc;
        int n;
        for (int c = 0; c < nch; c++) begin
            if (toggle) begin
                act_valid = 1'b0;
                @(posedge clk); #1;
            end
            act_in    = act_of(p, c);
            act_valid = 1'b1;
            if (c == start_at) start = 1'b1;
            n = 0;
            acc = 1'b0;
            while (!acc && n < 1000) begin
                @(negedge clk);
                acc = act_ready;
                @(posedge clk); #1;
                start = 1'b0;
                n++;
            end
            if (!acc) begin
                $display("FAIL accept_timeout: got no act_ready, expected accept of ch %0d", c);
                $fatal(1, "accept timeout");
            end
        end
        act_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) begin
            $display("FAIL idle_timeout: got busy=1, expected 0");
            $fatal(1, "idle timeout");
        end
    endtask

    task automatic start_frame();
        wait_idle();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic do_pixel(input int p, input bit toggle, input int start_at);
        fill_rom(p);
        exp_q.push_back(p);
        send_pixel(p, toggle, start_at, CH);
    endtask

    task automatic check_reset_state(input string tag);
        @(negedge clk);
        chk({tag, " act_ready"}, act_ready, 0);
        chk({tag, " out_valid"}, out_valid, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " done"}, done, 0);
        chk({tag, " rom_addr"}, rom_addr, 0);
        chk({tag, " res_out"}, res_out, 0);
    endtask

    // Monitor: scoreboard pop on each output handshake, latency and done checks.
    initial begin
        bit ov_prev = 1'b0;
        bit done_prev = 1'b0;
        int p;
        forever begin
            @(negedge clk);
            if (rst) begin
                frame_hs = 0;
            end else begin
                if (act_valid && act_ready && rom_addr == ADDR'(CH - 1)) last_acc_cyc = cyc;
                if (out_valid && !ov_prev) chk("latency", cyc - last_acc_cyc, 2);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_output", 1, 0);
                    end else begin
                        p = exp_q.pop_front();
                        for (int l = 0; l < NUM; l++)
                            chk($sformatf("res p%0d lane%0d", p, l), lane_val(res_out, l), exp_lane(p, l));
                    end
                    frame_hs++;
                end
                if (done) begin
                    done_cnt++;
                    chk("done_handshakes", frame_hs, NPIX);
                    chk("done_busy", busy, 0);
                    chk("done_width", done_prev, 0);
                    frame_hs = 0;
                end
            end
            ov_prev   = out_valid;
            done_prev = done;
        end
    end

    // Downstream ready: hold off one output for 5 cycles when armed.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (bp_arm && out_valid) begin
                bp_arm    = 1'b0;
                out_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    for (int l = 0; l < NUM; l++)
                        chk($sformatf("bp hold lane%0d", l), lane_val(res_out, l), exp_lane(exp_q[0], l));
                    chk("bp act_ready", act_ready, 0);
                    chk("bp out_valid", out_valid, 1);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; act_in = '0; act_valid = 1'b0;
        fill_rom(0);
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Frame 1: continuous stream.
        start_frame();
        do_pixel(0, 1'b0, -1);
        do_pixel(1, 1'b0, -1);
        do_pixel(4, 1'b0, -1);

        // Frame 2: 50% input gaps, start pulse mid-pixel, output backpressure.
        start_frame();
        do_pixel(2, 1'b1, 30);
        bp_arm = 1'b1;
        do_pixel(3, 1'b0, -1);
        do_pixel(4, 1'b1, -1);

        // Frame 3: reset arrives with channel 60 of the first pixel.
        start_frame();
        fill_rom(0);
        send_pixel(0, 1'b0, -1, 60);
        act_in = act_of(0, 60); act_valid = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        act_valid = 1'b0;
        check_reset_state("midreset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Frame 4: clean restart after the aborted frame.
        start_frame();
        do_pixel(3, 1'b0, -1);
        do_pixel(2, 1'b0, -1);
        do_pixel(0, 1'b0, -1);

        wait_idle();
        repeat (4) @(posedge clk);
        #1;
        chk("done_count", done_cnt, 3);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fire4_squeeze_engine.md
FIRE4_SQUEEZE_ENGINE -- requirements
Module: fire4_squeeze_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 16: activation, weight and output word width in bits, signed fixed-point.
REQ-002 SHALL have parameter ADDR, default 10: weight ROM address width.
REQ-003 SHALL have parameter NUM, default 32: output channels, which is also the number of parallel MAC lanes.
REQ-004 SHALL have parameter CH, default 128: input channels per pixel, which is also the number of ROM words used.
REQ-005 SHALL have parameter NPIX, default 729: pixels per frame.
REQ-006 SHALL have parameter FRAC, default 8: fractional bits of the fixed-point format.
REQ-007 SHALL have a single clock and a synchronous, active-high reset.
REQ-008 Ports, in order: name, direction, width, meaning.
- clk, in, 1: the single clock.
- rst, in, 1: synchronous reset, active-high.
- start, in, 1: begins a frame; sampled only in IDLE.
- act_in, in, WIDTH: input activation, channel-major within a pixel.
- act_valid, in, 1: act_in is valid.
- act_ready, out, 1: block accepts act_in this cycle.
- rom_addr, out, ADDR: weight ROM address; the ROM returns data one cycle later.
- w_in, in, NUM x WIDTH: the NUM weights returned by the ROM.
- res_out, out, NUM x WIDTH: per-channel results for one pixel.
- out_valid, out, 1: res_out is valid.
- out_ready, in, 1: downstream accepts res_out.
- busy, out, 1: high in any state except IDLE.
- done, out, 1: single-cycle pulse after the last pixel of a frame is accepted.

Function
REQ-009 States: IDLE, RUN, DRAIN, OUT.
- IDLE to RUN on start; pixel counter and channel counter cleared, accumulators cleared.
REQ-010 In RUN: act_ready = 1; a transfer occurs when act_valid && act_ready.
REQ-011 rom_addr SHALL combinationally equal the channel counter (zero-extended) in every state; it is 0 outside RUN.
REQ-012 Each transfer SHALL register act_in into act_d, set the pipeline flag v_d, and increment the channel counter.
REQ-013 When v_d is set, each lane i SHALL add the full-precision signed product act_d*w_in[i] into a signed accumulator of 2*WIDTH+8 bits on the next edge (weight-to-activation alignment = 1 cycle).
REQ-014 A transfer with channel counter = CH-1 SHALL move the FSM to DRAIN and wrap the counter to 0; act_ready = 0 in DRAIN.
REQ-015 DRAIN SHALL last exactly 1 cycle, then go to OUT; the final product is accumulated on the DRAIN exit edge.
REQ-016 In OUT, out_valid = 1 and res_out[i] = sat_WIDTH(acc[i] >>> FRAC), using arithmetic shift and signed saturation to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-017 res_out SHALL be held stable while out_valid && !out_ready.
REQ-018 On OUT && out_ready:
- accumulators cleared and pixel counter incremented;
- if pixel counter = NPIX-1: go to IDLE and pulse done in the next cycle;
- otherwise go to RUN.
REQ-019 Latency: first out_valid SHALL rise 2 cycles after the edge accepting channel CH-1.
REQ-020 start SHALL be ignored outside IDLE; act_valid SHALL be ignored outside RUN.
REQ-021 When act_valid deasserts mid-pixel, the block SHALL stall with no counter or accumulator change; v_d SHALL clear the cycle after a non-transfer.

Reset
REQ-022 On rst, regardless of state, the block SHALL on the next edge:
- return to IDLE;
- clear counters, accumulators, act_d and v_d;
- drive act_ready=0, out_valid=0, busy=0, done=0, rom_addr=0 and res_out=0.
REQ-023 Reset asserted mid-frame SHALL discard the partial pixel; no done pulse SHALL be produced.

Configuration
REQ-024 Macro FIRE4_SQUEEZE_RELU_EN:
- defined: res_out[i] = 0 whenever the saturated value is negative (ReLU fused);
- undefined: the signed saturated value SHALL pass unchanged.

Structure
REQ-025 A shared package fire_pkg SHALL hold:
- the FSM state enum;
- the accumulator-width constant;
- the saturation function.
REQ-026 One sub-module, fire_mac_lane, SHALL implement a single lane (multiply, accumulate, clear, shift/saturate/ReLU); it is instantiated NUM times via generate.

Verification
REQ-027 Single pixel: CH=128, all act=1.0 (256) and all weights=1.0 (256) -> res_out[i]=128.0 (32767 saturated at WIDTH=16), out_valid exactly 2 cycles after the last accept.
REQ-028 Sign/ReLU: act=-0.5 (-128), weights=1.0 -> -64.0 (-16384) without the macro; 0 with FIRE4_SQUEEZE_RELU_EN.
REQ-029 Backpressure:
- act_valid toggled 50% -> results identical to the continuous run;
- out_ready held low 5 cycles -> res_out stable and act_ready=0 throughout.
REQ-030 Frame end: NPIX=3 -> exactly 3 out_valid handshakes, then done pulses 1 cycle and busy falls.
REQ-031 Reset mid-pixel at channel 60: no output; a new start then produces correct results from channel 0.
REQ-032 start while busy -> ignored; pixel and channel counts unaffected.
